pipe_trace_monitor: RTL and testbench

PIPE_TRACE_MONITOR -- requirements
Module: pipe_trace_monitor

---
 rtl/pipe_trace_monitor_if.sv | 22 ++
 rtl/pipe_trace_monitor.sv | 162 ++++++++++++++++
 tb/tb_pipe_trace_monitor.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_trace_monitor_if.sv
// Retirement trace input and readout handshake between a pipeline and its trace monitor.
interface pipe_trace_monitor_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_instr;
  logic        wb_bubble;
  logic        if_flush;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;

  modport master (
    output wb_valid, wb_pc, wb_instr, wb_bubble, if_flush, rd_ready,
    input  rd_valid, rd_pc, rd_instr
  );

  modport slave (
    input  wb_valid, wb_pc, wb_instr, wb_bubble, if_flush, rd_ready,
    output rd_valid, rd_pc, rd_instr
  );
endinterface

// File: rtl/pipe_trace_monitor.sv
// Pipeline trace monitor: captures retired {pc, instr} into a circular buffer,
// optionally stops a fixed number of entries after a PC trigger, drains the
// frozen buffer oldest-first, and keeps saturating pipeline event counters.
module pipe_trace_monitor #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [31:0]          trig_pc,
  input  logic [3:0]           count_sel,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     count_out,
  output logic                 overflow,
  pipe_trace_monitor_if.slave  bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned NUM_CNT = 9;
  localparam logic [AW:0]   OCC_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr, rd_ptr, post_cnt;
  logic [AW:0]        occ;
  logic               overflow_q;
  logic               capture, pop, post_load, post_dec;
  logic [NUM_CNT-1:0] inc;
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic [31:0]        mem_pc    [DEPTH];
  logic [31:0]        mem_instr [DEPTH];
  logic [6:0]         opcode;

  assign opcode = bus.wb_instr[6:0];

  // Next-state and per-cycle capture/pop decisions
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    pop       = 1'b0;
    post_load = 1'b0;
    post_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && occ == '0) state_d = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_d = FROZEN;
        end else if (bus.wb_valid) begin
          capture = 1'b1;
          if (mode && bus.wb_pc == trig_pc) begin
            post_load = 1'b1;
            state_d   = (POST_TRIG == 0) ? FROZEN : POST;
          end
        end
      end
      POST: begin
        if (!enable) begin
          state_d = FROZEN;
        end else if (bus.wb_valid) begin
          capture  = 1'b1;
          post_dec = 1'b1;
          if (post_cnt == AW'(1)) state_d = FROZEN;
        end
      end
      FROZEN: begin
        if (occ == '0) state_d = IDLE;
        else           pop     = bus.rd_ready;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter increment requests, only while capturing
  always_comb begin
    inc = '0;
    if (state_q == ARMED || state_q == POST) begin
      inc[0] = 1'b1;
      inc[1] = bus.wb_valid;
      inc[2] = bus.wb_valid && opcode == 7'b0000011;
      inc[3] = bus.wb_valid && opcode == 7'b0100011;
      inc[4] = bus.wb_valid && opcode == 7'b1100011;
      inc[5] = bus.wb_valid && opcode == 7'b0110011;
      inc[6] = bus.wb_valid && opcode == 7'b0010011;
      inc[7] = bus.wb_bubble;
      inc[8] = bus.if_flush;
    end
  end

  // Control state, pointers, occupancy, overflow and counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      post_cnt   <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
    end else if (clear) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      post_cnt   <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
    end else begin
      state_q <= state_d;
      if (post_load)     post_cnt <= POST_INIT;
      else if (post_dec) post_cnt <= post_cnt - 1'b1;
      // A full buffer drops its oldest entry so occupancy never exceeds DEPTH
      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (occ == OCC_FULL) begin
          rd_ptr     <= rd_ptr + 1'b1;
          overflow_q <= 1'b1;
        end else begin
          occ <= occ + 1'b1;
        end
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        occ    <= occ - 1'b1;
      end
      for (int unsigned i = 0; i < NUM_CNT; i++)
        if (inc[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  // Trace storage, not reset
  always_ff @(posedge clock) begin
    if (capture && !clear) begin
      mem_pc[wr_ptr]    <= bus.wb_pc;
      mem_instr[wr_ptr] <= bus.wb_instr;
    end
  end

  // Counter readout mux; unused selects read zero
  always_comb begin
    count_out = '0;
    if (int'(count_sel) < NUM_CNT) count_out = cnt[count_sel];
  end

  assign bus.rd_valid = (state_q == FROZEN) && (occ != '0);
  assign bus.rd_pc    = mem_pc[rd_ptr];
  assign bus.rd_instr = mem_instr[rd_ptr];
  assign state        = state_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Directed bench for pipe_trace_monitor: wrap capture, overflow, PC trigger,
// event counters, counter saturation, reset and clear.
module tb_pipe_trace_monitor;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] trig_pc = '0;
  logic [3:0]  count_sel = '0;
  logic [1:0]  state, state2;
  logic [31:0] count_out;
  logic [3:0]  count_out2;
  logic        overflow, overflow2;

  pipe_trace_monitor_if bus ();
  pipe_trace_monitor_if bus2 ();

  assign bus2.wb_valid  = bus.wb_valid;
  assign bus2.wb_pc     = bus.wb_pc;
  assign bus2.wb_instr  = bus.wb_instr;
  assign bus2.wb_bubble = bus.wb_bubble;
  assign bus2.if_flush  = bus.if_flush;
  assign bus2.rd_ready  = bus.rd_ready;

  pipe_trace_monitor #(.DEPTH(16), .POST_TRIG(4), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable), .mode(mode),
    .trig_pc(trig_pc), .count_sel(count_sel), .state(state),
    .count_out(count_out), .overflow(overflow), .bus(bus.slave)
  );

  pipe_trace_monitor #(.DEPTH(16), .POST_TRIG(4), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable), .mode(mode),
    .trig_pc(trig_pc), .count_sel(count_sel), .state(state2),
    .count_out(count_out2), .overflow(overflow2), .bus(bus2.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic        bub;
    logic        fl;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [10];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_cnt(input string name, input logic [3:0] sel, input logic [31:0] exp);
    count_sel = sel;
    #1;
    chk(name, count_out, exp);
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    bus.wb_valid = 1'b1;
    bus.wb_pc    = pc;
    bus.wb_instr = instr;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Pops while rd_valid, checking PCs ascend by 4 from first_pc; returns entry count
  task automatic drain(input string name, input logic [31:0] first_pc, output int unsigned n);
    int unsigned guard;
    n = 0;
    guard = 0;
    bus.rd_ready = 1'b1;
    while (bus.rd_valid && guard < 40) begin
      chk(name, bus.rd_pc, first_pc + 32'(4 * n));
      n++;
      guard++;
      tick();
    end
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    int unsigned n;
    vecs[0] = '{1'b1, 32'h00002003, 1'b0, 1'b0, 4'd2, 32'd1, "cnt_lw"};
    vecs[1] = '{1'b1, 32'h00002023, 1'b0, 1'b0, 4'd3, 32'd1, "cnt_sw"};
    vecs[2] = '{1'b1, 32'h00000063, 1'b0, 1'b0, 4'd4, 32'd1, "cnt_beq"};
    vecs[3] = '{1'b1, 32'h00000033, 1'b0, 1'b0, 4'd5, 32'd1, "cnt_add"};
    vecs[4] = '{1'b1, 32'h40000033, 1'b0, 1'b0, 4'd5, 32'd2, "cnt_sub"};
    vecs[5] = '{1'b1, 32'h00100013, 1'b0, 1'b0, 4'd6, 32'd1, "cnt_addi"};
    vecs[6] = '{1'b0, 32'h00002003, 1'b1, 1'b0, 4'd2, 32'd1, "lw_not_valid"};
    vecs[7] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 4'd7, 32'd2, "cnt_bubble2"};
    vecs[8] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 4'd7, 32'd3, "cnt_bubble3"};
    vecs[9] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 4'd8, 32'd1, "cnt_flush"};

    bus.wb_valid = 1'b0; bus.wb_pc = '0; bus.wb_instr = '0;
    bus.wb_bubble = 1'b0; bus.if_flush = 1'b0; bus.rd_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("reset_state", state, 2'd0);
    chk("reset_rd_valid", bus.rd_valid, 1'b0);
    reset = 1'b1;
    tick();
    chk("post_reset_state", state, 2'd0);
    chk("post_reset_overflow", overflow, 1'b0);
    chk_cnt("post_reset_retired", 4'd1, 32'd0);

    // Continuous capture of 5, freeze (uncaptured entry on freeze), drain
    enable = 1'b1;
    tick();
    chk("arm_state", state, 2'd1);
    for (int i = 0; i < 5; i++) retire(32'(4 * i), 32'h00000013 + 32'(i << 20));
    chk("armed_no_readout", bus.rd_valid, 1'b0);
    chk_cnt("t1_retired", 4'd1, 32'd5);
    chk_cnt("t1_cycles", 4'd0, 32'd5);
    chk_cnt("t1_addi", 4'd6, 32'd5);
    enable = 1'b0;
    retire(32'h100, 32'h00000013);
    chk("t1_frozen", state, 2'd3);
    chk("t1_first_instr", bus.rd_instr, 32'h00000013);
    drain("t1_pop_pc", 32'h0, n);
    chk("t1_pop_count", n, 32'd5);
    chk("t1_empty_frozen", state, 2'd3);
    tick();
    chk("t1_idle", state, 2'd0);

    // Overflow: 20 retirements into 16 entries; CNT_W=4 saturates
    do_clear();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) retire(32'(4 * i), 32'h00000033);
    enable = 1'b0;
    tick();
    chk("t2_frozen", state, 2'd3);
    chk("t2_overflow", overflow, 1'b1);
    chk_cnt("t2_retired", 4'd1, 32'd20);
    chk("t2_retired_sat", count_out2, 4'd15);
    drain("t2_pop_pc", 32'd16, n);
    chk("t2_pop_count", n, 32'd16);
    tick();
    chk("t2_idle", state, 2'd0);

    // PC trigger at 0x20 with 4 post-trigger entries
    do_clear();
    chk("t3_overflow_cleared", overflow, 1'b0);
    mode = 1'b1;
    trig_pc = 32'h20;
    enable = 1'b1;
    tick();
    for (int i = 0; i <= 16; i++) begin
      retire(32'(4 * i), 32'h00000013);
      if (i == 8)  chk("t3_post", state, 2'd2);
      if (i == 11) chk("t3_still_post", state, 2'd2);
      if (i == 12) chk("t3_frozen", state, 2'd3);
    end
    enable = 1'b0;
    chk_cnt("t3_retired", 4'd1, 32'd13);
    drain("t3_pop_pc", 32'h0, n);
    chk("t3_pop_count", n, 32'd13);
    mode = 1'b0;
    tick();

    // Event counters, table-driven
    do_clear();
    enable = 1'b1;
    tick();
    foreach (vecs[k]) begin
      bus.wb_valid  = vecs[k].v;
      bus.wb_instr  = vecs[k].instr;
      bus.wb_bubble = vecs[k].bub;
      bus.if_flush  = vecs[k].fl;
      tick();
      bus.wb_valid = 1'b0; bus.wb_bubble = 1'b0; bus.if_flush = 1'b0;
      chk_cnt(vecs[k].name, vecs[k].sel, vecs[k].exp);
    end
    chk_cnt("t4_retired", 4'd1, 32'd6);
    chk_cnt("t4_cycles", 4'd0, 32'd10);
    chk_cnt("t4_sel9", 4'd9, 32'd0);
    chk_cnt("t4_sel15", 4'd15, 32'd0);
    enable = 1'b0;
    tick();

    // Reset during readout with rd_ready held
    do_clear();
    enable = 1'b1;
    tick();
    retire(32'h40, 32'h0); retire(32'h44, 32'h0); retire(32'h48, 32'h0);
    enable = 1'b0;
    tick();
    chk("t5_frozen", state, 2'd3);
    bus.rd_ready = 1'b1;
    tick();
    chk("t5_after_pop", bus.rd_pc, 32'h44);
    #1 reset = 1'b0;
    count_sel = 4'd1;
    #1;
    chk("t5_rst_rd_valid", bus.rd_valid, 1'b0);
    chk("t5_rst_state", state, 2'd0);
    chk("t5_rst_retired", count_out, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("t5_release_state", state, 2'd0);
    chk("t5_release_rd_valid", bus.rd_valid, 1'b0);
    bus.rd_ready = 1'b0;

    // Clear while armed
    enable = 1'b1;
    tick();
    chk("t6_armed", state, 2'd1);
    retire(32'h80, 32'h0); retire(32'h84, 32'h0);
    chk_cnt("t6_retired_pre", 4'd1, 32'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    enable = 1'b0;
    chk("t6_clear_state", state, 2'd0);
    chk("t6_clear_rd_valid", bus.rd_valid, 1'b0);
    chk_cnt("t6_clear_retired", 4'd1, 32'd0);
    chk_cnt("t6_clear_cycles", 4'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
